// File: rtl/hamming_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
// Shared definitions for the Hamming(15,11) encode/correct path.
//   - word widths and parity bit positions
//   - occupancy states of the 2-entry output buffer
//   - codifica():        11-bit data -> 15-bit codeword (cw[i] is position i+1)
//   - mascara_injecao(): single-bit flip mask for error injection
//   - extrai_dado():     codeword -> data bits (used by the downstream corrector)
// -----------------------------------------------------------------------------
package hamming_pkg;

  localparam int LARG_DADO = 11;
  localparam int LARG_CW   = 15;
  localparam int LARG_POS  = 4;

  // Parity bits sit at the power-of-two positions 1, 2, 4, 8 (indices 0, 1, 3, 7).
  localparam int POS_P0 = 0;
  localparam int POS_P1 = 1;
  localparam int POS_P3 = 3;
  localparam int POS_P7 = 7;

  typedef enum logic [1:0] {
    VAZIO = 2'd0,
    UM    = 2'd1,
    DOIS  = 2'd2
  } ocupacao_t;

  function automatic logic [LARG_CW-1:0] codifica(input logic [LARG_DADO-1:0] dado);
    logic [LARG_CW-1:0] cw;
    cw        = '0;
    cw[2]     = dado[0];
    cw[4]     = dado[1];
    cw[5]     = dado[2];
    cw[6]     = dado[3];
    cw[14:8]  = dado[10:4];
    // Each parity bit covers the positions whose 1-based index has that bit set.
    cw[POS_P0] = cw[2] ^ cw[4] ^ cw[6] ^ cw[8] ^ cw[10] ^ cw[12] ^ cw[14];
    cw[POS_P1] = cw[2] ^ cw[5] ^ cw[6] ^ cw[9] ^ cw[10] ^ cw[13] ^ cw[14];
    cw[POS_P3] = cw[4] ^ cw[5] ^ cw[6] ^ cw[11] ^ cw[12] ^ cw[13] ^ cw[14];
    cw[POS_P7] = cw[8] ^ cw[9] ^ cw[10] ^ cw[11] ^ cw[12] ^ cw[13] ^ cw[14];
    return cw;
  endfunction

  // Position 0 means "no flip" even when injection is enabled.
  function automatic logic [LARG_CW-1:0] mascara_injecao(input logic habilita,
                                                         input logic [LARG_POS-1:0] posicao);
    logic [LARG_CW-1:0] mascara;
    mascara = '0;
    if (habilita && (posicao != 4'd0)) begin
      mascara[posicao - 4'd1] = 1'b1;
    end
    return mascara;
  endfunction

  function automatic logic [LARG_DADO-1:0] extrai_dado(input logic [LARG_CW-1:0] cw);
    return {cw[14:8], cw[6], cw[5], cw[4], cw[2]};
  endfunction

endpackage

// File: rtl/buffer_saida_2.sv
// -----------------------------------------------------------------------------
// buffer_saida_2
// Two-entry valid/ready FIFO for encoded codewords. The head entry drives the
// read side directly from a register, so leitura_dado is stable under
// backpressure and keeps its last value when the buffer drains.
//
// State table:
//   state | meaning
//   VAZIO | no entries, leitura_valida=0
//   UM    | one entry in cabeca
//   DOIS  | two entries (cabeca, segunda), escrita_pronta=0
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   escrita_dado     word to write
//   escrita_valida   write request
//   escrita_pronta   FIFO has room (registered state only)
//   leitura_dado     head word
//   leitura_valida   head word is valid
//   leitura_pronta   consumer takes the head word
// -----------------------------------------------------------------------------
module buffer_saida_2
  import hamming_pkg::*;
#(
  parameter int PROFUNDIDADE = 2,
  parameter int LARGURA      = LARG_CW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LARGURA-1:0] escrita_dado,
  input  logic               escrita_valida,
  output logic               escrita_pronta,
  output logic [LARGURA-1:0] leitura_dado,
  output logic               leitura_valida,
  input  logic               leitura_pronta
);

  ocupacao_t          estado;
  ocupacao_t          prox_estado;
  logic [1:0]         ocupacao;
  logic [LARGURA-1:0] cabeca;
  logic [LARGURA-1:0] segunda;
  logic               empurra;
  logic               retira;
  logic               carrega_cabeca;
  logic               cabeca_de_segunda;
  logic               carrega_segunda;

  assign ocupacao       = estado;
  assign escrita_pronta = (ocupacao < 2'(PROFUNDIDADE));
  assign leitura_valida = (estado != VAZIO);
  assign leitura_dado   = cabeca;

  assign empurra = escrita_valida & escrita_pronta;
  assign retira  = leitura_valida & leitura_pronta;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= VAZIO;
    end else begin
      estado <= prox_estado;
    end
  end

  always_comb begin
    prox_estado       = estado;
    carrega_cabeca    = 1'b0;
    cabeca_de_segunda = 1'b0;
    carrega_segunda   = 1'b0;
    unique case (estado)
      VAZIO: begin
        if (empurra) begin
          prox_estado    = UM;
          carrega_cabeca = 1'b1;
        end
      end
      UM: begin
        case ({empurra, retira})
          // Simultaneous push and pop: the incoming word replaces the head.
          2'b11: carrega_cabeca = 1'b1;
          2'b10: begin
            prox_estado     = DOIS;
            carrega_segunda = 1'b1;
          end
          2'b01: prox_estado = VAZIO;
          default: ;
        endcase
      end
      DOIS: begin
        if (retira) begin
          prox_estado       = UM;
          cabeca_de_segunda = 1'b1;
        end
      end
      default: prox_estado = VAZIO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cabeca  <= '0;
      segunda <= '0;
    end else begin
      if (carrega_cabeca) begin
        cabeca <= escrita_dado;
      end else if (cabeca_de_segunda) begin
        cabeca <= segunda;
      end
      if (carrega_segunda) begin
        segunda <= escrita_dado;
      end
    end
  end

endmodule

// File: rtl/codificador_hamming_fluxo.sv
// -----------------------------------------------------------------------------
// codificador_hamming_fluxo
// Streaming Hamming(15,11) encoder. Each accepted 11-bit word is encoded,
// optionally has one codeword bit flipped (error injection for exercising the
// corrector), and is queued in a 2-entry output buffer.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   entrada          data word to encode
//   entrada_valida   entrada valid this cycle
//   entrada_pronta   block accepts a word this cycle (registered state only)
//   inj_habilita     inject an error into the word accepted this cycle
//   inj_posicao      1-based position to flip (1..15), 0 = no flip
//   saida            codeword at the buffer head
//   saida_valida     saida is valid
//   saida_pronta     consumer accepts saida this cycle
//   contador         accepted words, modulo 2^LARGURA_CONT
// -----------------------------------------------------------------------------
module codificador_hamming_fluxo
  import hamming_pkg::*;
#(
  parameter int PROFUNDIDADE = 2,
  parameter int LARGURA_CONT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LARG_DADO-1:0]    entrada,
  input  logic                    entrada_valida,
  output logic                    entrada_pronta,
  input  logic                    inj_habilita,
  input  logic [LARG_POS-1:0]     inj_posicao,
  output logic [LARG_CW-1:0]      saida,
  output logic                    saida_valida,
  input  logic                    saida_pronta,
  output logic [LARGURA_CONT-1:0] contador
);

  logic [LARG_CW-1:0] palavra;
  logic               aceita;

  // Injection is applied after parity so the stored word carries a real error.
  assign palavra = codifica(entrada) ^ mascara_injecao(inj_habilita, inj_posicao);
  assign aceita  = entrada_valida & entrada_pronta;

  always_ff @(posedge clk) begin
    if (rst) begin
      contador <= '0;
    end else if (aceita) begin
      contador <= contador + LARGURA_CONT'(1);
    end
  end

  buffer_saida_2 #(
    .PROFUNDIDADE (PROFUNDIDADE),
    .LARGURA      (LARG_CW)
  ) u_buffer (
    .clk            (clk),
    .rst            (rst),
    .escrita_dado   (palavra),
    .escrita_valida (entrada_valida),
    .escrita_pronta (entrada_pronta),
    .leitura_dado   (saida),
    .leitura_valida (saida_valida),
    .leitura_pronta (saida_pronta)
  );

endmodule

// File: tb/tb_codificador_hamming_fluxo.sv
// -----------------------------------------------------------------------------
// tb_codificador_hamming_fluxo
// Self-checking bench: constant vector table, hand-written multi-cycle
// sequences, and a scoreboard fed by an independent encoder/corrector model.
// A second instance with a 4-bit counter shares all inputs to exercise wrap.
// -----------------------------------------------------------------------------
module tb_codificador_hamming_fluxo;

  logic        clk;
  logic        rst;
  logic [10:0] entrada;
  logic        entrada_valida;
  logic        entrada_pronta;
  logic        inj_habilita;
  logic [3:0]  inj_posicao;
  logic [14:0] saida;
  logic        saida_valida;
  logic        saida_pronta;
  logic [15:0] contador;

  logic        entrada_pronta_p;
  logic [14:0] saida_p;
  logic        saida_valida_p;
  logic [3:0]  contador_p;

  int checks = 0;
  int errors = 0;

  codificador_hamming_fluxo dut (
    .clk            (clk),
    .rst            (rst),
    .entrada        (entrada),
    .entrada_valida (entrada_valida),
    .entrada_pronta (entrada_pronta),
    .inj_habilita   (inj_habilita),
    .inj_posicao    (inj_posicao),
    .saida          (saida),
    .saida_valida   (saida_valida),
    .saida_pronta   (saida_pronta),
    .contador       (contador)
  );

  codificador_hamming_fluxo #(.LARGURA_CONT(4)) dut_p (
    .clk            (clk),
    .rst            (rst),
    .entrada        (entrada),
    .entrada_valida (entrada_valida),
    .entrada_pronta (entrada_pronta_p),
    .inj_habilita   (inj_habilita),
    .inj_posicao    (inj_posicao),
    .saida          (saida_p),
    .saida_valida   (saida_valida_p),
    .saida_pronta   (saida_pronta),
    .contador       (contador_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent models: parity over positions with the matching index bit set.
  function automatic logic [14:0] model_cw(input logic [10:0] d);
    logic [14:0] c;
    int k;
    c = '0;
    k = 0;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[k];
        k++;
      end
    end
    for (int b = 1; b <= 8; b = b * 2) begin
      logic par;
      par = 1'b0;
      for (int p = 1; p <= 15; p++) begin
        if (((p & b) != 0) && (p != b)) par = par ^ c[p-1];
      end
      c[b-1] = par;
    end
    return c;
  endfunction

  function automatic logic [10:0] model_dec(input logic [14:0] cw);
    logic [14:0] c;
    logic [10:0] d;
    int s;
    int k;
    c = cw;
    d = '0;
    s = 0;
    k = 0;
    for (int p = 1; p <= 15; p++) begin
      if (c[p-1]) s = s ^ p;
    end
    if (s != 0) c[s-1] = ~c[s-1];
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p-1];
        k++;
      end
    end
    return d;
  endfunction

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nome, atual, esperado, $time);
    end
  endtask

  // Scoreboard ------------------------------------------------------------------
  typedef struct {
    logic [14:0] cw;
    logic [10:0] dado;
  } esperado_t;

  esperado_t sb[$];
  int        exp_cnt = 0;
  bit        ativo = 1'b0;

  always @(negedge clk) begin
    esperado_t e;
    if (ativo) begin
      chk("saida_valida", 32'(saida_valida), 32'(sb.size() != 0));
      chk("entrada_pronta", 32'(entrada_pronta), 32'(sb.size() < 2));
      chk("contador", 32'(contador), 32'(exp_cnt[15:0]));
      chk("contador_p", 32'(contador_p), 32'(exp_cnt[3:0]));
    end
    if (rst) begin
      ativo = 1'b1;
      sb.delete();
      exp_cnt = 0;
    end else if (ativo) begin
      if (saida_valida && saida_pronta) begin
        if (sb.size() == 0) begin
          chk("pop_sem_esperado", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("saida_ordem", 32'(saida), 32'(e.cw));
          chk("corretor", 32'(model_dec(saida)), 32'(e.dado));
          chk("saida_p", 32'(saida_p), 32'(e.cw));
        end
      end
      if (entrada_valida && entrada_pronta) begin
        e.dado = entrada;
        e.cw   = model_cw(entrada);
        if (inj_habilita && (inj_posicao != 4'd0)) e.cw[inj_posicao-1] = ~e.cw[inj_posicao-1];
        sb.push_back(e);
        exp_cnt++;
      end
    end
  end

  // Stimulus helpers -----------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    entrada_valida = 1'b0;
    saida_pronta = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_word(input logic [10:0] d, input logic en, input logic [3:0] pos);
    logic acc;
    entrada = d;
    inj_habilita = en;
    inj_posicao = pos;
    entrada_valida = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) begin
      acc = entrada_pronta;
      tick();
    end
    entrada_valida = 1'b0;
    inj_habilita = 1'b0;
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    saida_pronta = 1'b1;
    for (int k = 0; k < 100 && sb.size() != 0; k++) tick();
    chk("drain_vazio", 32'(sb.size()), 32'd0);
    tick();
  endtask

  typedef struct {
    logic [10:0] dado;
    logic        inj_en;
    logic [3:0]  inj_pos;
    logic [14:0] cw;
  } vetor_t;

  vetor_t tab[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [14:0] w0_cw;
    int          aceitos;

    tab[0] = '{11'h000, 1'b0, 4'd0,  15'h0000};
    tab[1] = '{11'h001, 1'b0, 4'd0,  15'h0007};
    tab[2] = '{11'h7FF, 1'b0, 4'd0,  15'h7FFF};
    tab[3] = '{11'h000, 1'b1, 4'd5,  15'h0010};
    tab[4] = '{11'h000, 1'b1, 4'd0,  15'h0000};
    tab[5] = '{11'h000, 1'b0, 4'd5,  15'h0000};
    tab[6] = '{11'h7FF, 1'b1, 4'd15, 15'h3FFF};
    tab[7] = '{11'h001, 1'b1, 4'd1,  15'h0006};

    rst = 1'b1;
    entrada = '0;
    entrada_valida = 1'b0;
    inj_habilita = 1'b0;
    inj_posicao = '0;
    saida_pronta = 1'b0;
    tick();
    do_reset();

    chk("rst_saida", 32'(saida), 32'd0);
    chk("rst_saida_valida", 32'(saida_valida), 32'd0);
    chk("rst_contador", 32'(contador), 32'd0);
    chk("rst_entrada_pronta", 32'(entrada_pronta), 32'd1);

    // Table: one word at a time, visible one edge after acceptance.
    saida_pronta = 1'b1;
    for (int i = 0; i < 8; i++) begin
      entrada = tab[i].dado;
      inj_habilita = tab[i].inj_en;
      inj_posicao = tab[i].inj_pos;
      entrada_valida = 1'b1;
      tick();
      entrada_valida = 1'b0;
      inj_habilita = 1'b0;
      chk("tab_saida", 32'(saida), 32'(tab[i].cw));
      chk("tab_valida", 32'(saida_valida), 32'd1);
      chk("tab_contador", 32'(contador), 32'(i + 1));
      chk("tab_corretor", 32'(model_dec(saida)), 32'(tab[i].dado));
      tick();
      chk("tab_vazio", 32'(saida_valida), 32'd0);
      chk("tab_saida_mantida", 32'(saida), 32'(tab[i].cw));
    end

    // Backpressure: two words fill the buffer, the third waits.
    do_reset();
    push_word(11'h123, 1'b0, 4'd0);
    w0_cw = model_cw(11'h123);
    chk("bp_saida_w0", 32'(saida), 32'(w0_cw));
    chk("bp_pronta_um", 32'(entrada_pronta), 32'd1);
    push_word(11'h456, 1'b0, 4'd0);
    chk("bp_pronta_dois", 32'(entrada_pronta), 32'd0);
    entrada = 11'h789;
    entrada_valida = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_saida_estavel", 32'(saida), 32'(w0_cw));
      chk("bp_pronta_baixa", 32'(entrada_pronta), 32'd0);
    end
    saida_pronta = 1'b1;
    push_word(11'h789, 1'b0, 4'd0);
    drain();
    chk("bp_contador_3", 32'(contador), 32'd3);

    // Push and pop together in UM: new word becomes head.
    do_reset();
    push_word(11'h0AA, 1'b0, 4'd0);
    saida_pronta = 1'b1;
    entrada = 11'h555;
    entrada_valida = 1'b1;
    tick();
    entrada_valida = 1'b0;
    saida_pronta = 1'b0;
    chk("um_pushpop_saida", 32'(saida), 32'(model_cw(11'h555)));
    chk("um_pushpop_valida", 32'(saida_valida), 32'd1);
    chk("um_pushpop_pronta", 32'(entrada_pronta), 32'd1);
    drain();

    // Reset in DOIS with simultaneous push and pop: reset wins.
    saida_pronta = 1'b0;
    push_word(11'h111, 1'b0, 4'd0);
    push_word(11'h222, 1'b0, 4'd0);
    chk("dois_pronta", 32'(entrada_pronta), 32'd0);
    rst = 1'b1;
    entrada = 11'h333;
    entrada_valida = 1'b1;
    saida_pronta = 1'b1;
    tick();
    rst = 1'b0;
    entrada_valida = 1'b0;
    saida_pronta = 1'b0;
    chk("rst_dois_valida", 32'(saida_valida), 32'd0);
    chk("rst_dois_contador", 32'(contador), 32'd0);
    chk("rst_dois_saida", 32'(saida), 32'd0);
    chk("rst_dois_pronta", 32'(entrada_pronta), 32'd1);

    // Counter wrap on the 4-bit instance.
    saida_pronta = 1'b1;
    for (int k = 0; k < 15; k++) push_word(11'(k * 37), 1'b0, 4'd0);
    chk("wrap_p_15", 32'(contador_p), 32'd15);
    chk("wrap_pronta_p", 32'(entrada_pronta_p), 32'd1);
    push_word(11'h7FF, 1'b0, 4'd0);
    chk("wrap_p_0", 32'(contador_p), 32'd0);
    chk("wrap_16", 32'(contador), 32'd16);
    drain();
    chk("wrap_vazio_p", 32'(saida_valida_p), 32'd0);

    // Random data, random injection, random handshakes.
    do_reset();
    aceitos = 0;
    for (int k = 0; k < 20000 && aceitos < 1000; k++) begin
      entrada = 11'($urandom);
      inj_habilita = 1'($urandom);
      inj_posicao = 4'($urandom);
      entrada_valida = (($urandom % 4) != 0);
      saida_pronta = (($urandom % 4) != 0);
      if (entrada_valida && entrada_pronta) aceitos++;
      tick();
    end
    entrada_valida = 1'b0;
    inj_habilita = 1'b0;
    chk("rand_aceitos", 32'(aceitos), 32'd1000);
    drain();
    chk("rand_contador", 32'(contador), 32'd1000);
    chk("rand_contador_p", 32'(contador_p), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
